// File: rtl/mnist_pkg.sv
// Shared constants and types for the MNIST argmax stage.
package mnist_pkg;

    localparam int NUM_CLASSES = 10;
    localparam int SCORE_W     = 16;
    localparam int IDX_W       = 4;

    typedef logic [SCORE_W-1:0] score_t;
    typedef logic [IDX_W-1:0]   idx_t;

    localparam idx_t LAST_IDX = IDX_W'(NUM_CLASSES - 1);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        HOLD
    } state_t;

endpackage

// File: rtl/mnist_argmax_if.sv
// Score input and prediction output bundle of the argmax stage.
interface mnist_argmax_if;
    import mnist_pkg::*;

    logic                           scores_valid;
    logic [NUM_CLASSES*SCORE_W-1:0] digit_scores;
    logic                           pred_ready;
    logic                           pred_valid;
    idx_t                           pred_digit;
    score_t                         pred_score;
    score_t                         pred_margin;
    logic                           busy;

    // Environment side: supplies scores and accepts predictions.
    modport master (
        output scores_valid, digit_scores, pred_ready,
        input  pred_valid, pred_digit, pred_score, pred_margin, busy
    );

    // Argmax block side.
    modport slave (
        input  scores_valid, digit_scores, pred_ready,
        output pred_valid, pred_digit, pred_score, pred_margin, busy
    );

endinterface

// File: rtl/mnist_top2_update.sv
// One step of a running top-2 search: folds score s at index idx into
// the current maximum / runner-up. Ties go to the later index.
module mnist_top2_update
    import mnist_pkg::*;
(
    input  score_t s,
    input  idx_t   idx,
    input  score_t cur_max,
    input  score_t cur_second,
    input  idx_t   cur_digit,
    output score_t next_max,
    output score_t next_second,
    output idx_t   next_digit
);

    // Compare s against both trackers (unsigned) and shift as needed.
    always_comb begin
        // NOTE: combinational logic uses blocking '=' and assigns every output a default first, so no latch can be inferred.
        next_max    = cur_max;
        next_second = cur_second;
        next_digit  = cur_digit;
        if (s >= cur_max) begin
            next_second = cur_max;
            next_max    = s;
            next_digit  = idx;
        end else if (s >= cur_second) begin
            next_second = s;
        end
    end

endmodule

// File: rtl/mnist_argmax.sv
// Captures the packed class scores on a rising scores_valid, scans them
// one per cycle for max and runner-up, then offers digit/score/margin
// on a valid/ready handshake.
module mnist_argmax
    import mnist_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    mnist_argmax_if.slave bus
);

    state_t state_q, state_d;

    score_t buf_q [NUM_CLASSES];
    idx_t   idx_q;
    score_t max_q;
    score_t second_q;
    idx_t   digit_q;
    logic   valid_q;

    logic   pred_valid_q;
    idx_t   pred_digit_q;
    score_t pred_score_q;
    score_t pred_margin_q;

    logic   rise;
    score_t scan_s;
    score_t max_nx;
    score_t second_nx;
    idx_t   digit_nx;

    assign rise   = bus.scores_valid & ~valid_q;
    assign scan_s = buf_q[idx_q];

    mnist_top2_update u_top2 (
        .s           (scan_s),
        .idx         (idx_q),
        .cur_max     (max_q),
        .cur_second  (second_q),
        .cur_digit   (digit_q),
        .next_max    (max_nx),
        .next_second (second_nx),
        .next_digit  (digit_nx)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking '<=' so every register samples pre-edge values.
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic: capture on rise, scan all classes, wait for handshake.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (rise) state_d = SCAN;
            SCAN: if (idx_q == LAST_IDX) state_d = HOLD;
            HOLD: if (pred_valid_q && bus.pred_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Edge detector, score buffer and running top-2 trackers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q  <= 1'b0;
            idx_q    <= '0;
            max_q    <= '0;
            second_q <= '0;
            digit_q  <= '0;
            // NOTE: the buffer is cleared on reset so scores from an aborted image never linger.
            for (int i = 0; i < NUM_CLASSES; i++) buf_q[i] <= '0;
        end else begin
            valid_q <= bus.scores_valid;
            if (state_q == IDLE && rise) begin
                for (int i = 0; i < NUM_CLASSES; i++)
                    buf_q[i] <= bus.digit_scores[i*SCORE_W +: SCORE_W];
                idx_q    <= '0;
                max_q    <= '0;
                second_q <= '0;
                digit_q  <= '0;
            end else if (state_q == SCAN) begin
                max_q    <= max_nx;
                second_q <= second_nx;
                digit_q  <= digit_nx;
                if (idx_q != LAST_IDX) idx_q <= idx_q + 1'b1;
            end
        end
    end

    // Result registers: loaded on the first HOLD cycle, dropped after transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pred_valid_q  <= 1'b0;
            pred_digit_q  <= '0;
            pred_score_q  <= '0;
            pred_margin_q <= '0;
        end else if (state_q == HOLD) begin
            if (!pred_valid_q) begin
                pred_valid_q  <= 1'b1;
                pred_digit_q  <= digit_q;
                pred_score_q  <= max_q;
                pred_margin_q <= max_q - second_q;
            end else if (bus.pred_ready) begin
                pred_valid_q <= 1'b0;
            end
        end
    end

    assign bus.pred_valid  = pred_valid_q;
    assign bus.pred_digit  = pred_digit_q;
    assign bus.pred_score  = pred_score_q;
    assign bus.pred_margin = pred_margin_q;
    // The capture cycle is combinational on the input; gated by rst so
    // every output reads 0 while reset is asserted.
    assign bus.busy = !rst && ((state_q == SCAN) || (state_q == IDLE && rise));

endmodule

// File: tb/tb_mnist_argmax.sv
// Directed self-checking bench for mnist_argmax.
module tb_mnist_argmax;
    import mnist_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;
    score_t vec [NUM_CLASSES];

    always #5 clk = ~clk;

    mnist_argmax_if bus ();

    mnist_argmax dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_vec();
        for (int i = 0; i < NUM_CLASSES; i++)
            bus.digit_scores[i*SCORE_W +: SCORE_W] = vec[i];
    endtask

    // Waits for the result after the rise edge, checks latency and values,
    // lets it transfer (pred_ready must be 1) and checks valid drops.
    task automatic wait_result(input string tag, input idx_t e_digit,
                               input score_t e_score, input score_t e_margin);
        int cyc;
        cyc = 0;
        do begin
            step();
            cyc++;
            if (cyc == 5) check({tag, "_busy_scan"}, 32'(bus.busy), 32'd1);
        end while (!bus.pred_valid && cyc < 40);
        check({tag, "_latency"}, 32'(cyc - 1), 32'(NUM_CLASSES + 1));
        check({tag, "_busy_hold"}, 32'(bus.busy), 32'd0);
        check({tag, "_digit"}, 32'(bus.pred_digit), 32'(e_digit));
        check({tag, "_score"}, 32'(bus.pred_score), 32'(e_score));
        check({tag, "_margin"}, 32'(bus.pred_margin), 32'(e_margin));
        step();
        check({tag, "_valid_drop"}, 32'(bus.pred_valid), 32'd0);
    endtask

    task automatic run_eval(input string tag, input idx_t e_digit,
                            input score_t e_score, input score_t e_margin);
        load_vec();
        bus.scores_valid = 1'b1;
        wait_result(tag, e_digit, e_score, e_margin);
        bus.scores_valid = 1'b0;
        step();
    endtask

    initial begin
        #500us;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int hits;
        idx_t hit_digit;

        rst = 1'b1;
        bus.scores_valid = 1'b0;
        bus.digit_scores = '0;
        bus.pred_ready   = 1'b1;
        repeat (3) step();
        check("rst_valid",  32'(bus.pred_valid),  32'd0);
        check("rst_digit",  32'(bus.pred_digit),  32'd0);
        check("rst_score",  32'(bus.pred_score),  32'd0);
        check("rst_margin", 32'(bus.pred_margin), 32'd0);
        check("rst_busy",   32'(bus.busy),        32'd0);
        rst = 1'b0;
        step();
        check("idle_busy", 32'(bus.busy), 32'd0);

        // Basic pattern: max at class 2, runner-up at class 3.
        vec = '{16'h0100, 16'h0200, 16'h7F00, 16'h0300, 16'h0000,
                16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0050};
        run_eval("basic", 4'd2, 16'h7F00, 16'h7C00);

        // All equal: highest index wins, margin 0.
        for (int i = 0; i < NUM_CLASSES; i++) vec[i] = 16'h1234;
        run_eval("tie", 4'd9, 16'h1234, 16'h0000);

        for (int i = 0; i < NUM_CLASSES; i++) vec[i] = 16'h0000;
        run_eval("zero", 4'd9, 16'h0000, 16'h0000);

        // Unsigned compare at the top of the range.
        vec[0] = 16'hFFFF;
        for (int i = 1; i < NUM_CLASSES; i++) vec[i] = 16'hFFFE;
        run_eval("top", 4'd0, 16'hFFFF, 16'h0001);

        // Backpressure: outputs stable while stalled, inputs toggling.
        vec = '{16'h0A00, 16'h0B00, 16'h0C00, 16'h0100, 16'h0200,
                16'h0300, 16'h0400, 16'h2000, 16'h1F00, 16'h0000};
        load_vec();
        bus.pred_ready   = 1'b0;
        bus.scores_valid = 1'b1;
        hits = 0;
        while (!bus.pred_valid && hits < 40) begin
            step();
            hits++;
        end
        bus.scores_valid = 1'b0;
        check("bp_latency", 32'(hits - 1), 32'(NUM_CLASSES + 1));
        for (int c = 0; c < 20; c++) begin
            bus.digit_scores = {$urandom, $urandom, $urandom, $urandom, $urandom};
            bus.scores_valid = c[0];
            step();
            check("bp_valid",  32'(bus.pred_valid),  32'd1);
            check("bp_digit",  32'(bus.pred_digit),  32'd7);
            check("bp_score",  32'(bus.pred_score),  32'h2000);
            check("bp_margin", 32'(bus.pred_margin), 32'h0100);
        end
        bus.scores_valid = 1'b0;
        bus.pred_ready   = 1'b1;
        step();
        check("bp_transfer", 32'(bus.pred_valid), 32'd0);
        step();
        check("bp_after", 32'(bus.pred_valid), 32'd0);

        // Reset in the middle of a scan, scores_valid held across release.
        vec = '{16'h0300, 16'h0900, 16'h0100, 16'h0200, 16'h0050,
                16'h0800, 16'h0000, 16'h0000, 16'h0000, 16'h0001};
        load_vec();
        bus.scores_valid = 1'b1;
        repeat (6) step();
        check("mid_busy", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        #1;
        check("arst_valid",  32'(bus.pred_valid),  32'd0);
        check("arst_digit",  32'(bus.pred_digit),  32'd0);
        check("arst_score",  32'(bus.pred_score),  32'd0);
        check("arst_margin", 32'(bus.pred_margin), 32'd0);
        check("arst_busy",   32'(bus.busy),        32'd0);
        repeat (2) step();
        rst = 1'b0;
        wait_result("rst_rel", 4'd1, 16'h0900, 16'h0100);
        bus.scores_valid = 1'b0;
        step();

        // Long level with a second pulse mid-scan: exactly one result.
        vec = '{16'h0100, 16'h0200, 16'h7F00, 16'h0300, 16'h0000,
                16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0050};
        load_vec();
        bus.scores_valid = 1'b1;
        hits = 0;
        hit_digit = '0;
        for (int c = 0; c < 100; c++) begin
            if (c == 4) bus.scores_valid = 1'b0;
            if (c == 5) bus.scores_valid = 1'b1;
            step();
            if (bus.pred_valid) begin
                hits++;
                hit_digit = bus.pred_digit;
            end
        end
        check("level_results", 32'(hits), 32'd1);
        check("level_digit", 32'(hit_digit), 32'd2);
        bus.scores_valid = 1'b0;
        step();
        vec[0] = 16'hFFFF;
        for (int i = 1; i < NUM_CLASSES; i++) vec[i] = 16'hFFFE;
        run_eval("second", 4'd0, 16'hFFFF, 16'h0001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
